// File: rtl/mem_port_sequencer.sv
// ---------------------------------------------------------------------------
// mem_port_sequencer
//
// Shares one byte-wide synchronous memory port between an instruction-fetch
// requester and a data load/store requester. A fetch is two consecutive
// byte reads packed into one instruction word {byte@addr, byte@addr+1}. A
// data access is a single byte read or write. Simultaneous requests are
// settled round-robin on last_grant.
//
// Handshake: a requester raises req with its address (and we/wdata) and
// holds them until its one-cycle ack. Requests are sampled only in IDLE.
// A req still high in its own ack cycle is ignored, so a requester that
// keeps req high for one more cycle starts a fresh transaction.
//
// Ports:
//   clk, reset                 clock (rising edge), synchronous active-high reset
//   fetch_req/addr             fetch request and first-byte address
//   fetch_ack/instr            ack pulse, instruction word valid with ack
//   data_req/we/addr/wdata     data request, 1 = write
//   data_ack/rdata             ack pulse, read byte valid with ack
//   mem_addr/we/wdata          memory address, write strobe, write byte
//   mem_rdata                  memory read data, valid the cycle after mem_addr
//   busy                       high whenever the sequencer is not idle
//   last_grant                 0 = fetch, 1 = data was granted last
//   state_dbg                  raw FSM state for observation
//
// Latency from the IDLE cycle T that samples the request:
//   fetch ack T+4, data read ack T+3, data write ack T+2 (mem_we at T+1).
// ---------------------------------------------------------------------------
module mem_port_sequencer #(
    parameter int DATA_WIDTH        = 8,
    parameter int ADDR_WIDTH        = 12,
    parameter int INSTRUCTION_WIDTH = 2 * DATA_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         fetch_req,
    input  logic [ADDR_WIDTH-1:0]        fetch_addr,
    output logic                         fetch_ack,
    output logic [INSTRUCTION_WIDTH-1:0] fetch_instr,
    input  logic                         data_req,
    input  logic                         data_we,
    input  logic [ADDR_WIDTH-1:0]        data_addr,
    input  logic [DATA_WIDTH-1:0]        data_wdata,
    output logic                         data_ack,
    output logic [DATA_WIDTH-1:0]        data_rdata,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    output logic                         mem_we,
    output logic [DATA_WIDTH-1:0]        mem_wdata,
    input  logic [DATA_WIDTH-1:0]        mem_rdata,
    output logic                         busy,
    output logic                         last_grant,
    output logic [2:0]                   state_dbg
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        F0   = 3'd1,
        F1   = 3'd2,
        F2   = 3'd3,
        D0   = 3'd4,
        D1   = 3'd5
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic                    lat_we;
    logic [DATA_WIDTH-1:0]   lat_wdata;
    logic [DATA_WIDTH-1:0]   hi_reg;

    logic                    fetch_eff;
    logic                    data_eff;
    logic                    grant_fetch;
    logic                    grant_data;
    logic                    mem_we_raw;

    // A requester's own ack cycle masks its req so a held req is not
    // mistaken for a new transaction.
    assign fetch_eff   = fetch_req & ~fetch_ack;
    assign data_eff    = data_req  & ~data_ack;
    // On a tie, grant whoever was not granted last.
    assign grant_fetch = fetch_eff & (~data_eff | last_grant);
    assign grant_data  = data_eff  & (~fetch_eff | ~last_grant);

    always_comb begin
        state_next = state;
        mem_addr   = '0;
        mem_we_raw = 1'b0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                if (grant_fetch)     state_next = F0;
                else if (grant_data) state_next = D0;
            end
            F0: begin
                mem_addr   = lat_addr;
                state_next = F1;
            end
            F1: begin
                // Wraps modulo 2^ADDR_WIDTH by width truncation.
                mem_addr   = lat_addr + ADDR_WIDTH'(1);
                state_next = F2;
            end
            F2: begin
                state_next = IDLE;
            end
            D0: begin
                mem_addr = lat_addr;
                if (lat_we) begin
                    mem_we_raw = 1'b1;
                    mem_wdata  = lat_wdata;
                    state_next = IDLE;
                end else begin
                    state_next = D1;
                end
            end
            D1: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Gated by reset so an aborted write never reaches memory.
    assign mem_we    = mem_we_raw & ~reset;
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            fetch_ack   <= 1'b0;
            data_ack    <= 1'b0;
            fetch_instr <= '0;
            data_rdata  <= '0;
            last_grant  <= 1'b1;
            lat_addr    <= '0;
            lat_we      <= 1'b0;
            lat_wdata   <= '0;
            hi_reg      <= '0;
        end else begin
            state     <= state_next;
            fetch_ack <= 1'b0;
            data_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_fetch) begin
                        lat_addr   <= fetch_addr;
                        last_grant <= 1'b0;
                    end else if (grant_data) begin
                        lat_addr   <= data_addr;
                        lat_we     <= data_we;
                        lat_wdata  <= data_wdata;
                        last_grant <= 1'b1;
                    end
                end
                F1: hi_reg <= mem_rdata;
                F2: begin
                    fetch_instr <= {hi_reg, mem_rdata};
                    fetch_ack   <= 1'b1;
                end
                D0: begin
                    if (lat_we) data_ack <= 1'b1;
                end
                D1: begin
                    data_rdata <= mem_rdata;
                    data_ack   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
